mem_port_arbiter: RTL

- Shares one single-ported, fixed-latency memory between the pipeline's instruction-fetch port (IF stage) and its load/store port (MEM stage).
- Runs one transaction at a time through a small FSM and returns responses from registers.
- Drives per-port stall outputs that the pipeline uses to freeze IF/ID and the later stages while a port waits.
- Sits between PC/instruction-fetch logic, the MEM stage, and the shared memory macro.

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, data port, shared memory and stall bundle.
// slave = arbiter view; master = pipeline/memory view.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stall_if;
   logic        stall_mem;
   logic        busy;

   modport slave (
      input  if_req, if_addr,
      input  d_req, d_we, d_addr, d_wdata,
      input  mem_rdata,
      output if_gnt, if_ack, if_rdata,
      output d_gnt, d_ack, d_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output stall_if, stall_mem, busy
   );

   modport master (
      output if_req, if_addr,
      output d_req, d_we, d_addr, d_wdata,
      output mem_rdata,
      input  if_gnt, if_ack, if_rdata,
      input  d_gnt, d_ack, d_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  stall_if, stall_mem, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one transaction at a time between fetch and data ports.
// Define MEM_PORT_ARB_STARVE_EN to build the fetch-starvation override.
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CAPT,
      S_RESP
   } state_t;

   localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 1);

   state_t      state;
   logic        owner_if;
   logic        we_q;
   logic [2:0]  wait_cnt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] if_rdata_q;
   logic [31:0] d_rdata_q;
   logic        mem_en_q;
   logic        mem_we_q;
   logic        if_ack_q;
   logic        d_ack_q;
   logic        busy_q;

   logic        arb;
   logic        if_pend;
   logic        d_pend;
   logic        pick_if;
   logic        pick_d;
   logic        starved;

   // A port in its own ack cycle is not competing for the next grant.
   assign if_pend = bus.if_req & ~if_ack_q;
   assign d_pend  = bus.d_req & ~d_ack_q;
   assign arb     = rst & ((state == S_IDLE) | (state == S_RESP));
   assign pick_if = arb & if_pend & (~d_pend | starved);
   assign pick_d  = arb & d_pend & ~pick_if;

`ifdef MEM_PORT_ARB_STARVE_EN
   logic [3:0] starve_cnt;

   assign starved = (starve_cnt == 4'(STARVE_MAX));

   // Count data wins over a waiting fetch; any fetch win or idle fetch clears.
   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (arb) begin
         if (pick_if | ~if_pend)
            starve_cnt <= '0;
         else if (pick_d & ~starved)
            starve_cnt <= starve_cnt + 4'd1;
      end
   end
`else
   // Strict data-over-fetch priority; the starvation cap has no effect.
   wire [3:0] unused_starve_max = 4'(STARVE_MAX);

   assign starved = 1'b0;
`endif

   // Transaction FSM with registered memory strobes, acks and read data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         owner_if   <= 1'b0;
         we_q       <= 1'b0;
         wait_cnt   <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         mem_en_q <= 1'b0;
         mem_we_q <= 1'b0;
         if_ack_q <= 1'b0;
         d_ack_q  <= 1'b0;
         unique case (state)
            S_IDLE, S_RESP: begin
               if (pick_if | pick_d) begin
                  state    <= S_ISSUE;
                  owner_if <= pick_if;
                  we_q     <= pick_d & bus.d_we;
                  addr_q   <= pick_if ? bus.if_addr : bus.d_addr;
                  if (pick_d)
                     wdata_q <= bus.d_wdata;
                  mem_en_q <= 1'b1;
                  mem_we_q <= pick_d & bus.d_we;
                  busy_q   <= 1'b1;
               end else begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end
            end
            S_ISSUE: begin
               if (MEM_LAT <= 1) begin
                  state <= S_CAPT;
               end else begin
                  state    <= S_WAIT;
                  wait_cnt <= WAIT_INIT;
               end
            end
            S_WAIT: begin
               if (wait_cnt <= 3'd1)
                  state <= S_CAPT;
               else
                  wait_cnt <= wait_cnt - 3'd1;
            end
            S_CAPT: begin
               state <= S_RESP;
               if (owner_if) begin
                  if_rdata_q <= bus.mem_rdata;
                  if_ack_q   <= 1'b1;
               end else begin
                  d_rdata_q <= we_q ? 32'd0 : bus.mem_rdata;
                  d_ack_q   <= 1'b1;
               end
            end
            default: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.if_gnt    = pick_if;
   assign bus.d_gnt     = pick_d;
   assign bus.if_ack    = if_ack_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.stall_if  = rst & if_pend;
   assign bus.stall_mem = rst & d_pend;
   assign bus.busy      = busy_q;
endmodule
